dump_streamer: RTL and testbench

- Read-back path of the debug unit: streams the processor state out through the UART transmitter so the host can inspect a finished or halted run.
- The host loads a program by writing instruction memory and data memory. This block is the opposite direction: it reads PC, register file and data memory and serializes them byte-wise to the UART TX.
- Sits inside the debug unit, between the MIPS read ports and the UART transmitter.

---
 rtl/dump_pkg.sv | 27 ++
 rtl/dump_streamer_if.sv | 21 ++
 rtl/dump_streamer_word_serializer.sv | 35 +++
 rtl/dump_streamer.sv | 201 ++++++++++++++++++++
 tb/tb_dump_streamer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the debug read-back streamer.
// Used by the FSM in dump_streamer and by the word_serializer byte mux.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Which part of the processor state the current word belongs to
  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_MEM = 2'd2
  } section_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/dump_streamer_if.sv
// Byte-wide handshake between the dump streamer and the UART transmitter.
// master = byte producer (streamer), slave = UART TX.
interface dump_streamer_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_done
  );

endinterface

// File: rtl/dump_streamer_word_serializer.sv
// Holds one 32-bit word and presents the byte selected by i_byte_idx,
// most significant byte first (index 0 = bits 31:24).
module word_serializer
  import dump_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WORD_W-1:0]     i_word,
  input  logic [BYTE_IDX_W-1:0] i_byte_idx,
  output logic [7:0]            o_byte
);

  logic [WORD_W-1:0] r_buf;
  logic [7:0]        w_bytes [BYTES_PER_WORD];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_word;
    end
  end

  // Big-endian byte lanes: lane 0 is the top byte of the buffer
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign w_bytes[gi] = r_buf[WORD_W-1-8*gi -: 8];
    end
  endgenerate

  assign o_byte = w_bytes[i_byte_idx];

endmodule

// File: rtl/dump_streamer.sv
// Debug read-back: streams PC, register file and data memory to the UART TX,
// one 32-bit word at a time, MSB first.
module dump_streamer
  import dump_pkg::*;
#(
  parameter int N_REGS      = 32,
  parameter int DMEM_WORDS  = 32,
  parameter int DMEM_ADDR_W = 32,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [31:0]            i_pc,
  output logic [REG_ADDR_W-1:0]  o_reg_addr,
  input  logic [31:0]            i_reg_data,
  output logic [DMEM_ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]            i_mem_data,
  dump_streamer_if.master        tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int MAX_WORDS = (N_REGS > DMEM_WORDS) ? N_REGS : DMEM_WORDS;
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(N_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(DMEM_WORDS - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  section_t                r_section;
  logic [IDX_W-1:0]        r_word_idx;
  logic [BYTE_IDX_W-1:0]   r_byte_idx;
  logic [REG_ADDR_W-1:0]   r_reg_addr;
  logic [DMEM_ADDR_W-1:0]  r_mem_addr;

  section_t                w_next_section;
  logic [IDX_W-1:0]        w_next_word_idx;
  logic                    w_more_words;
  logic                    w_load;
  logic [WORD_W-1:0]       w_load_word;
  logic [7:0]              w_byte;
  logic                    w_tx_start;
  logic                    w_busy;
  logic                    w_done;

  // Successor of the current word; empty sections are skipped
  always_comb begin
    w_more_words    = 1'b0;
    w_next_section  = r_section;
    w_next_word_idx = '0;
    case (r_section)
      SEC_PC: begin
        if (N_REGS > 0) begin
          w_more_words   = 1'b1;
          w_next_section = SEC_REG;
        end else if (DMEM_WORDS > 0) begin
          w_more_words   = 1'b1;
          w_next_section = SEC_MEM;
        end
      end
      SEC_REG: begin
        if (r_word_idx != LAST_REG) begin
          w_more_words    = 1'b1;
          w_next_word_idx = r_word_idx + 1'b1;
        end else if (DMEM_WORDS > 0) begin
          w_more_words   = 1'b1;
          w_next_section = SEC_MEM;
        end
      end
      SEC_MEM: begin
        if (r_word_idx != LAST_MEM) begin
          w_more_words    = 1'b1;
          w_next_word_idx = r_word_idx + 1'b1;
        end
      end
      default: begin
        w_more_words = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_tx_start   = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_load       = 1'b1;
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_tx_start   = 1'b1;
        w_state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx.tx_done) begin
          if (r_byte_idx != LAST_BYTE_IDX) begin
            w_state_next = ST_SEND;
          end else if (w_more_words) begin
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_busy       = 1'b0;
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Addresses update on entry to FETCH so they are stable through LATCH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_section  <= SEC_PC;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_reg_addr <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_section  <= SEC_PC;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
        end
        ST_LATCH: begin
          r_byte_idx <= '0;
        end
        ST_WAIT_TX: begin
          if (tx.tx_done) begin
            if (r_byte_idx != LAST_BYTE_IDX) begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end else if (w_more_words) begin
              r_section  <= w_next_section;
              r_word_idx <= w_next_word_idx;
              if (w_next_section == SEC_MEM) begin
                r_mem_addr <= DMEM_ADDR_W'({w_next_word_idx, 2'b00});
              end else begin
                r_reg_addr <= REG_ADDR_W'(w_next_word_idx);
              end
            end
          end
        end
        default: begin
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

  assign w_load_word = (r_state == ST_IDLE)   ? i_pc       :
                       (r_section == SEC_MEM) ? i_mem_data : i_reg_data;

  word_serializer u_serializer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_word     (w_load_word),
    .i_byte_idx (r_byte_idx),
    .o_byte     (w_byte)
  );

  assign tx.tx_data  = w_byte;
  assign tx.tx_start = w_tx_start;
  assign o_reg_addr  = r_reg_addr;
  assign o_mem_addr  = r_mem_addr;
  assign o_busy      = w_busy;
  assign o_done      = w_done;

endmodule

// File: tb/tb_dump_streamer.sv
// Directed bench for dump_streamer with N_REGS=2, DMEM_WORDS=1 and a
// behavioural UART TX whose done latency is programmable.
module tb_dump_streamer;

  localparam int NR = 2;
  localparam int NM = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start_drv = 1'b0;
  logic        stray_start = 1'b0;
  logic        i_start;
  logic [31:0] i_pc = 32'h0000_0010;
  logic [4:0]  o_reg_addr;
  logic [31:0] reg_rd;
  logic [31:0] o_mem_addr;
  logic [31:0] mem_rd;
  logic        o_busy;
  logic        o_done;
  logic        model_done = 1'b0;
  logic        extra_done = 1'b0;

  dump_streamer_if tx_if ();

  assign i_start       = i_start_drv | stray_start;
  assign tx_if.tx_done = model_done | extra_done;

  dump_streamer #(
    .N_REGS      (NR),
    .DMEM_WORDS  (NM),
    .DMEM_ADDR_W (32),
    .REG_ADDR_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_pc       (i_pc),
    .o_reg_addr (o_reg_addr),
    .i_reg_data (reg_rd),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (mem_rd),
    .tx         (tx_if.master),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file and data memory with one-cycle registered read
  logic [31:0] regs_m [0:31];
  logic [31:0] mem_m  [0:31];
  always @(posedge clk) begin
    reg_rd <= regs_m[o_reg_addr];
    mem_rd <= mem_m[o_mem_addr[6:2]];
  end

  // Scenario controls, written only by the stimulus process
  int scn_id    = 0;
  int tx_delay  = 10;
  bit inject_en = 1'b0;
  bit stray_en  = 1'b0;

  // Monitor / TX model state, written only by the negedge process
  int         seen_id = 0;
  int         cnt = 0;
  int         inject = 0;
  int         done_cnt = 0;
  int         unstable = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] got_q [$];
  int         st_q [$];
  logic [4:0]  reg_log [0:8191];
  logic [31:0] mem_log [0:8191];

  always @(negedge clk) begin
    if (scn_id != seen_id) begin
      seen_id = scn_id;
      got_q.delete();
      st_q.delete();
      done_cnt = 0;
      unstable = 0;
    end
    if (cyc < 8192) begin
      reg_log[cyc] = o_reg_addr;
      mem_log[cyc] = o_mem_addr;
    end
    stray_start = 1'b0;
    model_done  = 1'b0;
    if (rst) begin
      cnt    = 0;
      inject = 0;
    end else begin
      if (cnt > 0) begin
        if (tx_if.tx_data !== cur_byte) unstable++;
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          if (inject_en && (got_q.size() % 4 == 0) && (got_q.size() < 16)) inject = 2;
        end
      end else if (inject > 0) begin
        model_done = 1'b1;
        inject--;
      end
      if (tx_if.tx_start) begin
        got_q.push_back(tx_if.tx_data);
        st_q.push_back(cyc);
        cur_byte = tx_if.tx_data;
        cnt      = tx_delay;
        if (stray_en && got_q.size() == 5) stray_start = 1'b1;
      end
      if (o_done) done_cnt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_words [4];

  task automatic run_dump(input string name, input int d, input bit inj, input bit stray,
                          input bit collide);
    int s;
    logic [31:0] w;
    tx_delay  = d;
    inject_en = inj;
    stray_en  = stray;
    scn_id++;
    tick();
    s = cyc;
    i_start_drv = 1'b1;
    if (collide) extra_done = 1'b1;
    tick();
    i_start_drv = 1'b0;
    extra_done  = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) tick();
    check($sformatf("%s.done_seen", name), 32'(done_cnt > 0), 32'd1);
    repeat (5) tick();
    check($sformatf("%s.done_count", name), 32'(done_cnt), 32'd1);
    check($sformatf("%s.busy_after", name), 32'(o_busy), 32'd0);
    check($sformatf("%s.byte_count", name), 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 4; i++) begin
      w = {got_q[4*i], got_q[4*i+1], got_q[4*i+2], got_q[4*i+3]};
      check($sformatf("%s.word%0d", name, i), w, exp_words[i]);
    end
    check($sformatf("%s.tx_data_stable", name), 32'(unstable), 32'd0);
    if (st_q.size() == 16) begin
      check($sformatf("%s.start_latency", name), 32'(st_q[0] - s), 32'd1);
      check($sformatf("%s.intra_spacing", name), 32'(st_q[1] - st_q[0]), 32'(d + 1));
      check($sformatf("%s.inter_spacing_pc_reg", name), 32'(st_q[4] - st_q[3]), 32'(d + 3));
      check($sformatf("%s.inter_spacing_reg_mem", name), 32'(st_q[12] - st_q[11]), 32'(d + 3));
    end
    $display("[TB] dump %s: delay=%0d bytes=%0d done_pulses=%0d", name, d, got_q.size(), done_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = 32'h0;
      mem_m[i]  = 32'h0;
    end
    regs_m[1] = 32'h1234_5678;
    mem_m[0]  = 32'hAABB_CDEF;
    exp_words[0] = 32'h0000_0010;
    exp_words[1] = 32'h0000_0000;
    exp_words[2] = 32'h1234_5678;
    exp_words[3] = 32'hAABB_CDEF;

    rst = 1'b1;
    repeat (3) tick();
    check("reset.tx_start", 32'(tx_if.tx_start), 32'd0);
    check("reset.tx_data",  32'(tx_if.tx_data),  32'd0);
    check("reset.busy",     32'(o_busy),         32'd0);
    check("reset.done",     32'(o_done),         32'd0);
    check("reset.reg_addr", 32'(o_reg_addr),     32'd0);
    check("reset.mem_addr", o_mem_addr,          32'd0);
    rst = 1'b0;
    tick();

    run_dump("basic", 10, 1'b0, 1'b0, 1'b0);
    if (st_q.size() == 16) begin
      check("basic.fetch_reg0_addr", 32'(reg_log[st_q[4] - 2]), 32'd0);
      check("basic.fetch_reg1_addr", 32'(reg_log[st_q[8] - 2]), 32'd1);
      check("basic.latch_reg1_addr", 32'(reg_log[st_q[8] - 1]), 32'd1);
      check("basic.fetch_mem0_addr", mem_log[st_q[12] - 2], 32'd0);
      check("basic.latch_mem0_addr", mem_log[st_q[12] - 1], 32'd0);
    end

    run_dump("stray_start", 10, 1'b0, 1'b1, 1'b0);

    // Abort in the middle of the ninth byte
    tx_delay  = 10;
    inject_en = 1'b0;
    stray_en  = 1'b0;
    scn_id++;
    tick();
    i_start_drv = 1'b1;
    tick();
    i_start_drv = 1'b0;
    for (int k = 0; k < 3000 && got_q.size() < 9; k++) tick();
    check("abort.reached_byte9", 32'(got_q.size()), 32'd9);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort.tx_start", 32'(tx_if.tx_start), 32'd0);
    check("abort.tx_data",  32'(tx_if.tx_data),  32'd0);
    check("abort.busy",     32'(o_busy),         32'd0);
    check("abort.done",     32'(o_done),         32'd0);
    check("abort.reg_addr", 32'(o_reg_addr),     32'd0);
    check("abort.mem_addr", o_mem_addr,          32'd0);
    rst = 1'b0;
    repeat (30) tick();
    check("abort.no_more_bytes", 32'(got_q.size()), 32'd9);
    $display("[TB] dump abort: bytes before reset=%0d", got_q.size());

    run_dump("after_reset", 10, 1'b0, 1'b0, 1'b0);
    run_dump("inject_done", 10, 1'b1, 1'b0, 1'b0);
    run_dump("zero_wait", 1, 1'b0, 1'b0, 1'b0);
    run_dump("collide", 1, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
